subtrator_serial: RTL and testbench
===================================

SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 Parameter WIDTH, default 6, operand and result width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  request to begin an operation; sampled on a rising edge.
REQ-005 Port modo  input  1  operation select: 0 = subtract (a - b), 1 = add (a + b).
REQ-006 Port a  input  WIDTH  minuend in subtract mode, first addend in add mode.
REQ-007 Port b  input  WIDTH  subtrahend in subtract mode, second addend in add mode.
REQ-008 Port emprestaEntrada  input  1  borrow-in in subtract mode, carry-in in add mode.
REQ-009 Port diferenca  output  WIDTH  registered result.
REQ-010 Port emprestaFinal  output  1  registered borrow-out in subtract mode, carry-out in add mode.
REQ-011 Port ocupado  output  1  high while bits are being processed.
REQ-012 Port pronto  output  1  one-cycle pulse marking a new valid result.
REQ-013 Port overflow  output  1  signed two's-complement overflow flag (see Configuration).

Function
REQ-014 The block SHALL be bit-serial: one full-subtractor/full-adder cell, processing one bit per clock, LSB first.
REQ-015 FSM states SHALL be OCIOSO, CALCULA and PRONTO.
REQ-016 In OCIOSO or PRONTO, start=1 SHALL be accepted: a, b, modo and emprestaEntrada are captured, the bit counter is cleared and the FSM enters CALCULA.
REQ-017 In PRONTO with start=0, the FSM SHALL return to OCIOSO.
REQ-018 In CALCULA, start SHALL be ignored, and input changes SHALL NOT affect the operation in progress.
REQ-019 Each CALCULA cycle SHALL process bit i: d_i = a_i ^ b_i ^ e_i. Subtract: e_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & e_i). Add: e_(i+1) = majority(a_i, b_i, e_i).
REQ-020 After WIDTH CALCULA cycles, the FSM SHALL enter PRONTO.
REQ-021 pronto SHALL be high exactly WIDTH rising edges after the edge that accepted start, and only for that one cycle.
REQ-022 ocupado SHALL be high in CALCULA only.
REQ-023 diferenca, emprestaFinal and overflow SHALL update only on the edge entering PRONTO, and SHALL hold their values until the next completion; partial results SHALL never be visible.
REQ-024 Back-to-back operation: start accepted in PRONTO SHALL give a next pronto WIDTH+1 cycles after the previous one.
REQ-025 Results SHALL be modulo 2^WIDTH (wrap-around); emprestaFinal carries the out-of-range bit.

Reset
REQ-026 reset=1 on a rising edge SHALL force OCIOSO and clear the counter, diferenca, emprestaFinal, overflow, ocupado and pronto to 0.
REQ-027 reset SHALL take priority over start.
REQ-028 Reset during CALCULA SHALL abort the operation and SHALL produce no pronto.

Configuration
REQ-029 With SUBTRATOR_SERIAL_OVERFLOW_EN defined:
- subtract mode: overflow = (a_msb != b_msb) & (d_msb != a_msb).
- add mode: overflow = (a_msb == b_msb) & (d_msb != a_msb).
- overflow is registered per REQ-023.
REQ-030 Without SUBTRATOR_SERIAL_OVERFLOW_EN, the overflow port SHALL remain present, tied to constant 0, with no overflow logic generated.

Verification (WIDTH=6, emprestaEntrada=0 unless stated)
REQ-031 Subtract 010101 - 001010 -> diferenca=001011, emprestaFinal=0, pronto exactly 6 edges after start accepted, ocupado high for 6 cycles.
REQ-032 Subtract 000001 - 000010 -> 111111, emprestaFinal=1; subtract 000000 - 000000 with emprestaEntrada=1 -> 111111, emprestaFinal=1.
REQ-033 Add 111111 + 000001 -> 000000, emprestaFinal=1; with the macro defined, subtract 100000 - 000001 -> 011111, overflow=1; without the macro, overflow=0 throughout.
REQ-034 Pulse start and change a/b in the 3rd CALCULA cycle -> no restart; result matches the originally captured operands.
REQ-035 Assert reset in the 4th CALCULA cycle -> all outputs 0 next cycle, no pronto; then start 000011 - 000001 -> 000010.
REQ-036 Hold start high across two operations -> pronto pulses spaced exactly 7 cycles apart, each result correct.

Source files
------------

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor/adder: one full-subtractor/full-adder cell, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SUBTRATOR_SERIAL_OVERFLOW_EN.
module subtrator_serial #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             modo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             emprestaEntrada,
  output logic [WIDTH-1:0] diferenca,
  output logic             emprestaFinal,
  output logic             ocupado,
  output logic             pronto,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  estado_t          estado_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] aShift_r;
  logic [WIDTH-1:0] bShift_r;
  logic [WIDTH-1:0] dShift_r;
  logic             modo_r;
  logic             emp_r;

  logic             aBit_s;
  logic             bBit_s;
  logic             dBit_s;
  logic             empNext_s;
  logic             lastBit_s;
  logic [WIDTH-1:0] resultNext_s;

`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
  logic             ovf_r;
  logic             ovfNext_s;
`endif

  // Single serial cell: current bit, next borrow/carry and the result with this bit shifted in.
  always_comb begin
    aBit_s       = aShift_r[0];
    bBit_s       = bShift_r[0];
    dBit_s       = aBit_s ^ bBit_s ^ emp_r;
    if (modo_r) begin
      empNext_s = (aBit_s & bBit_s) | (aBit_s & emp_r) | (bBit_s & emp_r);
    end else begin
      empNext_s = (~aBit_s & bBit_s) | (~(aBit_s ^ bBit_s) & emp_r);
    end
    lastBit_s    = (count_r == LAST_BIT);
    resultNext_s = {dBit_s, dShift_r[WIDTH-1:1]};
  end

`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
  // On the last cycle the cell sees the operand MSBs, so overflow is decided from them.
  always_comb begin
    if (modo_r) begin
      ovfNext_s = (aBit_s == bBit_s) & (dBit_s != aBit_s);
    end else begin
      ovfNext_s = (aBit_s != bBit_s) & (dBit_s != aBit_s);
    end
  end

  assign overflow = ovf_r;
`else
  assign overflow = 1'b0;
`endif

  // Control FSM and datapath; visible outputs only change on the edge entering PRONTO.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r      <= OCIOSO;
      count_r       <= '0;
      aShift_r      <= '0;
      bShift_r      <= '0;
      dShift_r      <= '0;
      modo_r        <= 1'b0;
      emp_r         <= 1'b0;
      diferenca     <= '0;
      emprestaFinal <= 1'b0;
      ocupado       <= 1'b0;
      pronto        <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
      ovf_r         <= 1'b0;
`endif
    end else begin
      case (estado_r)
        OCIOSO, PRONTO: begin
          pronto <= 1'b0;
          if (start) begin
            aShift_r <= a;
            bShift_r <= b;
            dShift_r <= '0;
            modo_r   <= modo;
            emp_r    <= emprestaEntrada;
            count_r  <= '0;
            ocupado  <= 1'b1;
            estado_r <= CALCULA;
          end else begin
            ocupado  <= 1'b0;
            estado_r <= OCIOSO;
          end
        end
        CALCULA: begin
          aShift_r <= {1'b0, aShift_r[WIDTH-1:1]};
          bShift_r <= {1'b0, bShift_r[WIDTH-1:1]};
          dShift_r <= resultNext_s;
          emp_r    <= empNext_s;
          if (lastBit_s) begin
            diferenca     <= resultNext_s;
            emprestaFinal <= empNext_s;
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
            ovf_r         <= ovfNext_s;
`endif
            ocupado       <= 1'b0;
            pronto        <= 1'b1;
            estado_r      <= PRONTO;
          end else begin
            count_r  <= count_r + CW'(1);
            ocupado  <= 1'b1;
            pronto   <= 1'b0;
            estado_r <= CALCULA;
          end
        end
        default: begin
          ocupado  <= 1'b0;
          pronto   <= 1'b0;
          estado_r <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (WIDTH=6): directed cases, randomized operations
// against an arithmetic reference model, input-change immunity, reset abort and back-to-back.
module tb_subtrator_serial;

  localparam int WIDTH = 6;

  logic             clk;
  logic             reset;
  logic             start;
  logic             modo;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             emprestaEntrada;
  logic [WIDTH-1:0] diferenca;
  logic             emprestaFinal;
  logic             ocupado;
  logic             pronto;
  logic             overflow;

  int passCount  = 0;
  int checkCount = 0;

  subtrator_serial #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .modo           (modo),
    .a              (a),
    .b              (b),
    .emprestaEntrada(emprestaEntrada),
    .diferenca      (diferenca),
    .emprestaFinal  (emprestaFinal),
    .ocupado        (ocupado),
    .pronto         (pronto),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic: returns {overflow, borrow/carry, result}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                             input logic im, input logic ie);
    int s;
    logic [WIDTH-1:0] d;
    logic c;
    logic o;
    if (im) begin
      s = int'(ia) + int'(ib) + int'(ie);
      c = (s >= (1 << WIDTH));
    end else begin
      s = int'(ia) - int'(ib) - int'(ie);
      c = (s < 0);
    end
    d = s[WIDTH-1:0];
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
    if (im) o = (ia[WIDTH-1] == ib[WIDTH-1]) && (d[WIDTH-1] != ia[WIDTH-1]);
    else    o = (ia[WIDTH-1] != ib[WIDTH-1]) && (d[WIDTH-1] != ia[WIDTH-1]);
`else
    o = 1'b0;
`endif
    return {o, c, d};
  endfunction

  // Drives one operation and reports what was observed; comparisons are done by the callers.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic im,
                        input logic ie, output logic [WIDTH-1:0] od, output logic ob, output logic oo,
                        output int lat, output int busy, output logic held, output logic prontoAfter);
    logic [WIDTH-1:0] d0;
    @(negedge clk);
    a = ia; b = ib; modo = im; emprestaEntrada = ie; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = diferenca;
    held = 1'b1;
    lat = 0;
    busy = 0;
    while (!pronto && lat < 20) begin
      if (ocupado) busy++;
      if (diferenca !== d0) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    od = diferenca;
    ob = emprestaFinal;
    oo = overflow;
    @(negedge clk);
    prontoAfter = pronto;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; modo = 1'b0; a = 6'd9; b = 6'd3; emprestaEntrada = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({diferenca, emprestaFinal, ocupado, pronto, overflow} !== {6'd0, 4'b0000}) begin
      $display("FAIL reset_outputs: got d=%b e=%b busy=%b pronto=%b ovf=%b, want all 0",
               diferenca, emprestaFinal, ocupado, pronto, overflow);
    end else passCount++;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({ocupado, pronto} !== 2'b00) begin
      $display("FAIL reset_idle: got busy=%b pronto=%b, want 0 0", ocupado, pronto);
    end else passCount++;
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] ta [5] = '{6'b010101, 6'b000001, 6'b000000, 6'b111111, 6'b100000};
    logic [WIDTH-1:0] tbv[5] = '{6'b001010, 6'b000010, 6'b000000, 6'b000001, 6'b000001};
    logic             tm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic             te [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] wd [5] = '{6'b001011, 6'b111111, 6'b111111, 6'b000000, 6'b011111};
    logic             wb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] od;
    logic ob, oo, held, pa, wo;
    int lat, busy;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tbv[i], tm[i], te[i], od, ob, oo, lat, busy, held, pa);
`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
      wo = (i == 4);
`else
      wo = 1'b0;
`endif
      checkCount++;
      if ({od, ob, oo} !== {wd[i], wb[i], wo}) begin
        $display("FAIL directed_%0d_result: got d=%b e=%b ovf=%b, want d=%b e=%b ovf=%b",
                 i, od, ob, oo, wd[i], wb[i], wo);
      end else passCount++;
      checkCount++;
      if (lat !== WIDTH || busy !== WIDTH) begin
        $display("FAIL directed_%0d_timing: got latency=%0d busy=%0d, want %0d %0d", i, lat, busy, WIDTH, WIDTH);
      end else passCount++;
      checkCount++;
      if (held !== 1'b1 || pa !== 1'b0) begin
        $display("FAIL directed_%0d_hold_pulse: got held=%b prontoAfter=%b, want 1 0", i, held, pa);
      end else passCount++;
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] ia, ib, od;
    logic im, ie, ob, oo, held, pa;
    logic [WIDTH+1:0] exp;
    int lat, busy;
    for (int i = 0; i < 40; i++) begin
      ia = WIDTH'($urandom);
      ib = WIDTH'($urandom);
      im = 1'($urandom);
      ie = 1'($urandom);
      exp = model(ia, ib, im, ie);
      run_op(ia, ib, im, ie, od, ob, oo, lat, busy, held, pa);
      checkCount++;
      if ({oo, ob, od} !== exp) begin
        $display("FAIL random_%0d: a=%b b=%b modo=%b e=%b got ovf/e/d=%b, want %b", i, ia, ib, im, ie,
                 {oo, ob, od}, exp);
      end else passCount++;
      checkCount++;
      if (lat !== WIDTH || busy !== WIDTH || held !== 1'b1 || pa !== 1'b0) begin
        $display("FAIL random_%0d_timing: got lat=%0d busy=%0d held=%b prontoAfter=%b", i, lat, busy, held, pa);
      end else passCount++;
    end
  endtask

  task automatic test_ignore_inputs;
    logic [WIDTH+1:0] exp;
    int lat;
    exp = model(6'd45, 6'd17, 1'b0, 1'b0);
    @(negedge clk);
    a = 6'd45; b = 6'd17; modo = 1'b0; emprestaEntrada = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (2) begin
      @(negedge clk);
      lat++;
    end
    a = 6'd3; b = 6'd60; modo = 1'b1; emprestaEntrada = 1'b1; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!pronto && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkCount++;
    if (lat !== WIDTH) begin
      $display("FAIL ignore_latency: got %0d, want %0d", lat, WIDTH);
    end else passCount++;
    checkCount++;
    if ({overflow, emprestaFinal, diferenca} !== exp) begin
      $display("FAIL ignore_result: got %b, want %b", {overflow, emprestaFinal, diferenca}, exp);
    end else passCount++;
    @(negedge clk);
    checkCount++;
    if ({ocupado, pronto} !== 2'b00) begin
      $display("FAIL ignore_no_restart: got busy=%b pronto=%b, want 0 0", ocupado, pronto);
    end else passCount++;
  endtask

  task automatic test_reset_abort;
    logic [WIDTH-1:0] od;
    logic ob, oo, held, pa, sawPronto;
    int lat, busy;
    @(negedge clk);
    a = 6'd20; b = 6'd5; modo = 1'b0; emprestaEntrada = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkCount++;
    if ({diferenca, emprestaFinal, ocupado, pronto, overflow} !== {6'd0, 4'b0000}) begin
      $display("FAIL abort_outputs: got d=%b e=%b busy=%b pronto=%b ovf=%b, want all 0",
               diferenca, emprestaFinal, ocupado, pronto, overflow);
    end else passCount++;
    sawPronto = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (pronto || ocupado) sawPronto = 1'b1;
    end
    checkCount++;
    if (sawPronto !== 1'b0) begin
      $display("FAIL abort_no_pronto: got activity=%b, want 0", sawPronto);
    end else passCount++;
    run_op(6'b000011, 6'b000001, 1'b0, 1'b0, od, ob, oo, lat, busy, held, pa);
    checkCount++;
    if ({od, ob, lat} !== {6'b000010, 1'b0, WIDTH}) begin
      $display("FAIL abort_followup: got d=%b e=%b lat=%0d, want 000010 0 %0d", od, ob, lat, WIDTH);
    end else passCount++;
  endtask

  task automatic test_back_to_back;
    logic [WIDTH+1:0] exp1, exp2, got1, got2;
    int cyc, p1, p2;
    exp1 = model(6'd50, 6'd13, 1'b1, 1'b0);
    exp2 = model(6'd7, 6'd40, 1'b0, 1'b1);
    @(negedge clk);
    a = 6'd50; b = 6'd13; modo = 1'b1; emprestaEntrada = 1'b0; start = 1'b1;
    cyc = 0; p1 = -1; p2 = -1; got1 = '0; got2 = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (i == 1) begin
        a = 6'd7; b = 6'd40; modo = 1'b0; emprestaEntrada = 1'b1;
      end
      if (pronto) begin
        if (p1 < 0) begin
          p1 = cyc; got1 = {overflow, emprestaFinal, diferenca};
        end else if (p2 < 0) begin
          p2 = cyc; got2 = {overflow, emprestaFinal, diferenca};
        end
      end
      if (p2 >= 0) break;
    end
    start = 1'b0;
    checkCount++;
    if (p1 !== WIDTH + 1 || p2 - p1 !== WIDTH + 1) begin
      $display("FAIL b2b_spacing: got first=%0d second=%0d, want %0d and spacing %0d", p1, p2, WIDTH + 1, WIDTH + 1);
    end else passCount++;
    checkCount++;
    if (got1 !== exp1) begin
      $display("FAIL b2b_result1: got %b, want %b", got1, exp1);
    end else passCount++;
    checkCount++;
    if (got2 !== exp2) begin
      $display("FAIL b2b_result2: got %b, want %b", got2, exp2);
    end else passCount++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_inputs();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
